// File: rtl/byte_arbiter2_pkg.sv
// ---------------------------------------------------------------------------
// ByteBusPkg
// Shared types for the two-requester byte-bus arbiter.
//   owner_e     : which requester owns a transfer or read return
//   arb_state_e : arbiter lock state (idle, locked to A, locked to B)
//   PTR_A/PTR_B : encoding of the round-robin priority pointer
// ---------------------------------------------------------------------------
package ByteBusPkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    // Pointer value that gives priority to the requester that did NOT just
    // complete; i_lastWasB=1 means B completed.
    function automatic logic next_ptr(input logic i_lastWasB);
        return i_lastWasB ? PTR_A : PTR_B;
    endfunction

endpackage

// File: rtl/byte_arbiter2_rrarb2.sv
// ---------------------------------------------------------------------------
// RrArb2
// Two-way priority selector. With a single request the requester is granted
// directly; with both requesting the pointer picks the winner.
// Ports:
//   req_i[1:0]  in  request vector, bit 0 = A, bit 1 = B
//   pointer_i   in  priority pointer, 0 = A preferred, 1 = B preferred
//   grant_o[1:0] out one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module RrArb2 (
    input  logic [1:0] req_i,
    input  logic       pointer_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = pointer_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/byte_arbiter2.sv
// ---------------------------------------------------------------------------
// byte_arbiter2
// Shares one downstream byte-bus between two upstream requesters (A, B).
// A granted request is forwarded combinationally; if the downstream stalls
// (memHold_i=1) the grant is locked to that requester until it completes.
// Read data returns one cycle after completion, steered by the recorded
// owner of the last completed transfer.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   a*_i / a*_o                   requester A request and response
//   b*_i / b*_o                   requester B request and response
//   mem*_o / memReadData_i,
//   memHold_i                     shared downstream port
// Parameters:
//   DATA_BYTE    data width in bytes
//   ADDR_SIZE    address width in bits
//   ROUND_ROBIN  1 = alternate priority after each completion, 0 = A fixed
// ---------------------------------------------------------------------------
module byte_arbiter2
    import ByteBusPkg::*;
#(
    parameter int DATA_BYTE   = 4,
    parameter int ADDR_SIZE   = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     aEnable_i,
    input  logic                     aIsWrite_i,
    input  logic [DATA_BYTE-1:0]     aWriteMask_i,
    input  logic [ADDR_SIZE-1:0]     aAddr_i,
    input  logic [DATA_BYTE*8-1:0]   aWriteData_i,
    output logic [DATA_BYTE*8-1:0]   aReadData_o,
    output logic                     aHold_o,

    input  logic                     bEnable_i,
    input  logic                     bIsWrite_i,
    input  logic [DATA_BYTE-1:0]     bWriteMask_i,
    input  logic [ADDR_SIZE-1:0]     bAddr_i,
    input  logic [DATA_BYTE*8-1:0]   bWriteData_i,
    output logic [DATA_BYTE*8-1:0]   bReadData_o,
    output logic                     bHold_o,

    output logic                     memEnable_o,
    output logic                     memIsWrite_o,
    output logic [DATA_BYTE-1:0]     memWriteMask_o,
    output logic [ADDR_SIZE-1:0]     memAddr_o,
    output logic [DATA_BYTE*8-1:0]   memWriteData_o,
    input  logic [DATA_BYTE*8-1:0]   memReadData_i,
    input  logic                     memHold_i
);

    arb_state_e r_state;
    arb_state_e w_stateNxt;
    logic       r_ptr;
    logic       w_ptrNxt;
    owner_e     r_rdOwner;
    owner_e     w_rdOwnerNxt;

    logic [1:0] w_arbGrant;
    logic       w_gntA;
    logic       w_gntB;
    logic       w_complete;

    RrArb2 u_rrArb (
        .req_i     ({bEnable_i, aEnable_i}),
        .pointer_i (r_ptr),
        .grant_o   (w_arbGrant)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PTR_A;
            r_rdOwner <= OWN_A;
        end else begin
            r_state   <= w_stateNxt;
            r_ptr     <= w_ptrNxt;
            r_rdOwner <= w_rdOwnerNxt;
        end
    end

    always_comb begin
        w_gntA         = 1'b0;
        w_gntB         = 1'b0;
        w_stateNxt     = ST_IDLE;
        w_ptrNxt       = r_ptr;
        w_rdOwnerNxt   = r_rdOwner;
        memEnable_o    = 1'b0;
        memIsWrite_o   = 1'b0;
        memWriteMask_o = '0;
        memAddr_o      = '0;
        memWriteData_o = '0;
        aHold_o        = 1'b1;
        bHold_o        = 1'b1;
        aReadData_o    = '0;
        bReadData_o    = '0;

        // Grant selection. While locked, the owner keeps the grant only as
        // long as it keeps enable high; dropping it releases the lock with
        // no grant this cycle and no pointer change.
        if (rst_i) begin
            case (r_state)
                ST_IDLE: begin
                    w_gntA = w_arbGrant[0];
                    w_gntB = w_arbGrant[1];
                end
                ST_OWN_A: w_gntA = aEnable_i;
                ST_OWN_B: w_gntB = bEnable_i;
                default: begin
                    w_gntA = 1'b0;
                    w_gntB = 1'b0;
                end
            endcase
        end

        if (w_gntA) begin
            memEnable_o    = 1'b1;
            memIsWrite_o   = aIsWrite_i;
            memWriteMask_o = aWriteMask_i;
            memAddr_o      = aAddr_i;
            memWriteData_o = aWriteData_i;
        end else if (w_gntB) begin
            memEnable_o    = 1'b1;
            memIsWrite_o   = bIsWrite_i;
            memWriteMask_o = bWriteMask_i;
            memAddr_o      = bAddr_i;
            memWriteData_o = bWriteData_i;
        end

        if (rst_i) begin
            aHold_o = w_gntA ? memHold_i : aEnable_i;
            bHold_o = w_gntB ? memHold_i : bEnable_i;
            // Read return follows the last completed owner, not the current
            // grant, so data from a completion lands even while the other
            // requester is already being served.
            if (r_rdOwner == OWN_A) begin
                aReadData_o = memReadData_i;
            end else if (r_rdOwner == OWN_B) begin
                bReadData_o = memReadData_i;
            end
        end

        w_complete = (w_gntA | w_gntB) & ~memHold_i;

        if (w_gntA && memHold_i) begin
            w_stateNxt = ST_OWN_A;
        end else if (w_gntB && memHold_i) begin
            w_stateNxt = ST_OWN_B;
        end

        if (w_complete) begin
            w_rdOwnerNxt = w_gntB ? OWN_B : OWN_A;
            if (ROUND_ROBIN != 0) begin
                w_ptrNxt = next_ptr(w_gntB);
            end
        end
    end

endmodule
